// File: rtl/tsv_lane_arbiter_pkg.sv
// Shared types and sizing helpers for the TSV lane arbiter.
// The arbiter and its interface import this package.
package tsv_link_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  // Far-layer receive buffers hold at most 15 slots.
  localparam int CRW = 4;

  function automatic int beats_f(input int dw, input int tw);
    return dw / tw;
  endfunction

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tsv_lane_arbiter_if.sv
// Requester and TSV-side signal bundle for tsv_lane_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface tsv_lane_arbiter_if import tsv_link_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int TW   = 4,
  parameter int IDW  = clog2_f(NREQ)
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [TW-1:0]      tsv_data;
  logic               tsv_valid;
  logic               tsv_first;
  logic               tsv_last;
  logic [IDW-1:0]     tsv_id;
  logic               tsv_parity;
  logic               tsv_credit;
  logic               busy;
  logic               cred_ovf;

  modport slave (
    input  req_valid, req_data, tsv_credit,
    output req_ready, tsv_data, tsv_valid, tsv_first, tsv_last,
           tsv_id, tsv_parity, busy, cred_ovf
  );

  modport master (
    output req_valid, req_data, tsv_credit,
    input  req_ready, tsv_data, tsv_valid, tsv_first, tsv_last,
           tsv_id, tsv_parity, busy, cred_ovf
  );

endinterface

// File: rtl/tsv_lane_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            any_grant
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_grant = found;

endmodule

// File: rtl/tsv_lane_arbiter.sv
// Round-robin, credit-flow-controlled serialiser of NREQ DW-bit words onto TW TSV lanes.
// Optional feature macro: TSV_PARITY_EN (even parity per beat on tsv_parity).
module tsv_lane_arbiter import tsv_link_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TW      = 4,
  parameter int CREDITS = 2
) (
  input  logic              clk1,
  input  logic              rst,
  tsv_lane_arbiter_if.slave bus
);

  localparam int BEATS = beats_f(DW, TW);
  localparam int IDW   = clog2_f(NREQ);
  localparam int BW    = (BEATS > 1) ? clog2_f(BEATS) : 1;

  if (DW % TW != 0) begin : g_dw_chk
    $error("tsv_lane_arbiter: DW must be a multiple of TW");
  end
  if (CREDITS < 1 || CREDITS > 15) begin : g_cred_chk
    $error("tsv_lane_arbiter: CREDITS must be in 1..15");
  end
  if (NREQ < 2) begin : g_nreq_chk
    $error("tsv_lane_arbiter: NREQ must be at least 2");
  end

  state_e          state_q, state_d;
  logic [CRW-1:0]  cred_q;
  logic [IDW-1:0]  ptr_q, id_q, win_id;
  logic [BW-1:0]   beat_q;
  logic [DW-1:0]   word_q, win_word, word_nxt;
  logic [NREQ-1:0] grant;
  logic            any_grant, accept, send, last_beat, ovf_q;

  rr_arbiter #(.NREQ(NREQ), .PW(IDW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign send      = (state_q == SEND);
  assign accept    = (state_q == IDLE) && any_grant && (cred_q != '0);
  assign last_beat = send && (beat_q == BW'(BEATS - 1));
  // Word is held right-aligned; each beat shifts the next slice into the low lanes.
  assign word_nxt  = word_q >> TW;

  always_comb begin
    win_word = '0;
    win_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_word = bus.req_data[i*DW +: DW];
        win_id   = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SEND;
      SEND:    if (last_beat) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= IDLE;
      cred_q  <= CRW'(CREDITS);
      ptr_q   <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q <= win_word;
        id_q   <= win_id;
        beat_q <= '0;
        ptr_q  <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
      end else if (send) begin
        word_q <= word_nxt;
        beat_q <= last_beat ? '0 : beat_q + BW'(1);
      end
      // A grant and a returned credit in the same cycle cancel out.
      if (accept && !bus.tsv_credit) begin
        cred_q <= cred_q - CRW'(1);
      end else if (!accept && bus.tsv_credit) begin
        if (cred_q == CRW'(CREDITS)) ovf_q  <= 1'b1;
        else                         cred_q <= cred_q + CRW'(1);
      end
    end
  end

  assign bus.req_ready = accept ? grant : '0;
  assign bus.tsv_valid = send;
  assign bus.tsv_data  = send ? word_q[TW-1:0] : '0;
  assign bus.tsv_id    = send ? id_q : '0;
  assign bus.tsv_first = send && (beat_q == '0);
  assign bus.tsv_last  = last_beat;
  assign bus.busy      = send;
  assign bus.cred_ovf  = ovf_q;

`ifdef TSV_PARITY_EN
  logic par_q;

  always_ff @(posedge clk1) begin
    if (rst)                     par_q <= 1'b0;
    else if (accept)             par_q <= ^win_word[TW-1:0];
    else if (send && !last_beat) par_q <= ^word_nxt[TW-1:0];
    else                         par_q <= 1'b0;
  end

  assign bus.tsv_parity = par_q;
`else
  assign bus.tsv_parity = 1'b0;
`endif

endmodule

// File: tb/tb_tsv_lane_arbiter.sv
// Directed bench for tsv_lane_arbiter with a queue-based reference model checked every cycle.
module tb_tsv_lane_arbiter;

  localparam int NREQ = 4, DW = 16, TW = 4, CREDITS = 2, BEATS = DW / TW;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  bit   chk_en = 1'b0;
  int   nvec = 0, nerr = 0;

  always #5 clk1 = ~clk1;

  tsv_lane_arbiter_if #(.NREQ(NREQ), .DW(DW), .TW(TW)) bus ();

  tsv_lane_arbiter #(.NREQ(NREQ), .DW(DW), .TW(TW), .CREDITS(CREDITS)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of beats still owed on the TSV, a credit count and an RR pointer.
  typedef struct { logic [TW-1:0] d; bit f; bit l; int id; } beat_t;
  beat_t mq[$];
  int    m_cred = CREDITS, m_ptr = 0;
  bit    m_ovf = 1'b0;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (((v >> ((p + k) % NREQ)) & 1) != 0) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int exp_win();
    if (mq.size() != 0 || m_cred == 0) return -1;
    return pick(bus.req_valid, m_ptr);
  endfunction

  always @(posedge clk1) begin
    int w;
    logic [DW-1:0] wd;
    beat_t b;
    w = exp_win();
    if (rst) begin
      mq.delete();
      m_cred = CREDITS; m_ptr = 0; m_ovf = 1'b0;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      else if (w >= 0) begin
        wd = bus.req_data >> (w * DW);
        for (int k = 0; k < BEATS; k++) begin
          b.d = TW'((wd >> (k * TW)) & 16'hF);
          b.f = (k == 0); b.l = (k == BEATS - 1); b.id = w;
          mq.push_back(b);
        end
        m_ptr = (w + 1) % NREQ;
      end
      if (w >= 0 && !bus.tsv_credit) m_cred--;
      else if (w < 0 && bus.tsv_credit) begin
        if (m_cred == CREDITS) m_ovf = 1'b1;
        else m_cred++;
      end
    end
  end

  always @(negedge clk1) begin
    int w;
    logic [TW-1:0] ed;
    if (chk_en) begin
      w = exp_win();
      chk("req_ready", bus.req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
      ed = (mq.size() != 0) ? mq[0].d : '0;
      chk("tsv_valid", bus.tsv_valid, mq.size() != 0);
      chk("busy", bus.busy, mq.size() != 0);
      chk("tsv_data", bus.tsv_data, ed);
      chk("tsv_first", bus.tsv_first, (mq.size() != 0) ? mq[0].f : 1'b0);
      chk("tsv_last", bus.tsv_last, (mq.size() != 0) ? mq[0].l : 1'b0);
      chk("tsv_id", bus.tsv_id, (mq.size() != 0) ? mq[0].id : 0);
      chk("cred_ovf", bus.cred_ovf, m_ovf);
`ifdef TSV_PARITY_EN
      chk("tsv_parity", bus.tsv_parity, ^ed);
`else
      chk("tsv_parity", bus.tsv_parity, 1'b0);
`endif
    end
  end

  task automatic step();
    @(posedge clk1); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  logic [NREQ-1:0] gv[$];
  int gc[$];

  task automatic record(input int n);
    gv.delete(); gc.delete();
    for (int i = 0; i < n; i++) begin
      #1;
      if (bus.req_ready != 0) begin gv.push_back(bus.req_ready); gc.push_back(i); end
      step();
    end
  endtask

`ifdef TSV_PARITY_EN
  localparam logic PAR_B = 1'b1;
`else
  localparam logic PAR_B = 1'b0;
`endif

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.tsv_credit = 1'b0;
    step(); chk_en = 1'b1; step(); step();
    rst = 1'b0; #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.tsv_valid, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_ovf", bus.cred_ovf, 0);

    // Single word, LSB slice first.
    step(); bus.req_valid = 4'b0001; bus.req_data[15:0] = 16'hA5C3; #1;
    chk("t1_ready", bus.req_ready, 4'b0001);
    step(); bus.req_valid = '0; #1;
    chk("t1_b0", bus.tsv_data, 4'h3); chk("t1_first", bus.tsv_first, 1); chk("t1_id", bus.tsv_id, 0);
    step(); #1; chk("t1_b1", bus.tsv_data, 4'hC); chk("t1_nfirst", bus.tsv_first, 0);
    step(); #1; chk("t1_b2", bus.tsv_data, 4'h5);
    step(); #1; chk("t1_b3", bus.tsv_data, 4'hA); chk("t1_last", bus.tsv_last, 1);
    step(); #1; chk("t1_gap", bus.tsv_valid, 0);
    bus.tsv_credit = 1'b1; step(); bus.tsv_credit = 1'b0;

    // Parity beats 3 and B from requester 1 (pointer now 1).
    bus.req_valid = 4'b0010; bus.req_data[31:16] = 16'h00B3; #1;
    chk("t6_ready", bus.req_ready, 4'b0010);
    step(); bus.req_valid = '0; #1;
    chk("t6_b0", bus.tsv_data, 4'h3); chk("t6_par0", bus.tsv_parity, 0); chk("t6_id", bus.tsv_id, 1);
    step(); #1; chk("t6_b1", bus.tsv_data, 4'hB); chk("t6_par1", bus.tsv_parity, PAR_B);
    step(); step(); step();
    bus.tsv_credit = 1'b1; step(); bus.tsv_credit = 1'b0;

    // Round robin with a credit returned on every first beat.
    do_reset();
    bus.req_valid = 4'b1111; bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    gv.delete(); gc.delete();
    for (int i = 0; i < 25; i++) begin
      #1;
      if (bus.req_ready != 0) begin gv.push_back(bus.req_ready); gc.push_back(i); end
      bus.tsv_credit = bus.tsv_first;
      step();
    end
    bus.req_valid = '0; bus.tsv_credit = 1'b0;
    chk("t2_count", gv.size(), 5);
    for (int k = 0; k < 5 && k < gv.size(); k++) begin
      chk("t2_grant", gv[k], 32'd1 << (k % NREQ));
      chk("t2_cycle", gc[k], 5 * k);
    end

    // Credit stall: two words then no grant until a credit returns.
    do_reset();
    bus.req_valid = 4'b0111;
    record(14);
    chk("t3_count", gv.size(), 2);
    if (gv.size() == 2) begin
      chk("t3_g0", gv[0], 4'b0001); chk("t3_g1", gv[1], 4'b0010); chk("t3_c1", gc[1], 5);
    end
    #1; chk("t3_stall", bus.req_ready, 0);
    bus.tsv_credit = 1'b1; step(); bus.tsv_credit = 1'b0; #1;
    chk("t3_resume", bus.req_ready, 4'b0100);
    step(); bus.req_valid = '0;
    repeat (5) step();

    // Simultaneous accept+credit at credits=1, then overflow.
    do_reset();
    bus.req_valid = 4'b0001; #1; chk("t4_a0", bus.req_ready, 4'b0001);
    step(); bus.req_valid = '0; repeat (4) step();
    bus.req_valid = 4'b0001; bus.tsv_credit = 1'b1; #1; chk("t4_a1", bus.req_ready, 4'b0001);
    step(); bus.req_valid = '0; bus.tsv_credit = 1'b0; repeat (4) step();
    bus.req_valid = 4'b0001; #1; chk("t4_a2", bus.req_ready, 4'b0001);
    step(); bus.req_valid = '0; repeat (4) step();
    bus.req_valid = 4'b0001; #1; chk("t4_empty", bus.req_ready, 0);
    bus.req_valid = '0;
    bus.tsv_credit = 1'b1; repeat (3) step(); bus.tsv_credit = 1'b0; #1;
    chk("t4_ovf", bus.cred_ovf, 1);
    repeat (3) step(); chk("t4_ovf_sticky", bus.cred_ovf, 1);

    // Reset mid-word with pointer at 3.
    do_reset();
    chk("t5_ovf_clr", bus.cred_ovf, 0);
    bus.req_valid = 4'b0100; bus.req_data[47:32] = 16'h9876; #1;
    chk("t5_ready", bus.req_ready, 4'b0100);
    step(); bus.req_valid = '0; step(); step(); #1;
    chk("t5_beat2", bus.tsv_data, 4'h8);
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("t5_valid", bus.tsv_valid, 0); chk("t5_busy", bus.busy, 0);
    bus.req_valid = 4'b1001;
    record(12);
    bus.req_valid = '0;
    chk("t5_count", gv.size(), 2);
    if (gv.size() == 2) begin
      chk("t5_g0", gv[0], 4'b0001); chk("t5_g1", gv[1], 4'b1000);
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
